// File: rtl/exec_stage.sv
// RV32I Execute stage: forwarding, ALU, branch/jump resolution and the E/M pipeline register.
// Define RV32M_EN to build in the iterative multiply/divide unit; otherwise BusyE_o is tied low.
module exec_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteE_i,
    input  logic [1:0]        ResultSrcE_i,
    input  logic              MemWriteE_i,
    input  logic              JumpE_i,
    input  logic              JalrE_i,
    input  logic              BranchE_i,
    input  logic [2:0]        Funct3E_i,
    input  logic [3:0]        ALUControlE_i,
    input  logic              ALUSrcE_i,
    input  logic              MulDivE_i,
    input  logic [XLEN-1:0]   RD1E_i,
    input  logic [XLEN-1:0]   RD2E_i,
    input  logic [XLEN-1:0]   PCE_i,
    input  logic [XLEN-1:0]   PCPlus4E_i,
    input  logic [XLEN-1:0]   ImmExtE_i,
    input  logic [REG_AW-1:0] RdE_i,
    input  logic [1:0]        ForwardAE_i,
    input  logic [1:0]        ForwardBE_i,
    input  logic [XLEN-1:0]   ResultW_i,
    input  logic              FlushE_i,
    output logic              PCSrcE_o,
    output logic [XLEN-1:0]   PCTargetE_o,
    output logic              BusyE_o,
    output logic [XLEN-1:0]   ALUResultM_o,
    output logic [XLEN-1:0]   WriteDataM_o,
    output logic [XLEN-1:0]   PCPlus4M_o,
    output logic [REG_AW-1:0] RdM_o,
    output logic              RegWriteM_o,
    output logic              MemWriteM_o,
    output logic [1:0]        ResultSrcM_o
);
    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0]   src_a, write_data, src_b, alu_res, jalr_sum, m_result;
    logic [SW-1:0]     shamt;
    logic              br_eq, br_lt, br_ltu, br_take, busy, m_done;
    logic [XLEN-1:0]   alu_result_d, alu_result_q, write_data_d, write_data_q, pc_plus4_d, pc_plus4_q;
    logic [REG_AW-1:0] rd_d, rd_q;
    logic              reg_write_d, reg_write_q, mem_write_d, mem_write_q;
    logic [1:0]        result_src_d, result_src_q;

    always_comb begin : operands
        case (ForwardAE_i)
            2'b01:   src_a = ResultW_i;
            2'b10:   src_a = ALUResultM_o;
            default: src_a = RD1E_i;
        endcase
        case (ForwardBE_i)
            2'b01:   write_data = ResultW_i;
            2'b10:   write_data = ALUResultM_o;
            default: write_data = RD2E_i;
        endcase
        src_b = ALUSrcE_i ? ImmExtE_i : write_data;
        shamt = src_b[SW-1:0];
    end

    always_comb begin : alu
        alu_res = '0;
        case (ALUControlE_i)
            4'd0:  alu_res = src_a + src_b;
            4'd1:  alu_res = src_a - src_b;
            4'd2:  alu_res = src_a & src_b;
            4'd3:  alu_res = src_a | src_b;
            4'd4:  alu_res = src_a ^ src_b;
            4'd5:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            4'd6:  alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            4'd7:  alu_res = src_a << shamt;
            4'd8:  alu_res = src_a >> shamt;
            4'd9:  alu_res = $signed(src_a) >>> shamt;
            4'd10: alu_res = src_b;
            default: alu_res = '0;
        endcase
    end

    // Branches always compare against forwarded rs2, never the immediate.
    always_comb begin : branch
        br_eq  = (src_a == write_data);
        br_lt  = $signed(src_a) < $signed(write_data);
        br_ltu = src_a < write_data;
        case (Funct3E_i)
            3'b000:  br_take = br_eq;
            3'b001:  br_take = !br_eq;
            3'b100:  br_take = br_lt;
            3'b101:  br_take = !br_lt;
            3'b110:  br_take = br_ltu;
            3'b111:  br_take = !br_ltu;
            default: br_take = 1'b0;
        endcase
        jalr_sum    = src_a + ImmExtE_i;
        PCTargetE_o = JalrE_i ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0}) : (PCE_i + ImmExtE_i);
        PCSrcE_o    = !FlushE_i && !busy && (JumpE_i || (BranchE_i && br_take));
    end

`ifdef RV32M_EN
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} m_state_e;
    localparam int CW = $clog2(XLEN + 1);

    m_state_e          m_state_q, m_state_d;
    logic [CW-1:0]     m_cnt_q, m_cnt_d;
    logic [2*XLEN-1:0] m_acc_q, m_acc_d, m_step, m_full;
    logic [XLEN-1:0]   m_opb_q, m_opb_d, mag_a, mag_b, div_val, div_diff;
    logic [2:0]        m_op_q, m_op_d;
    logic              m_neg_q, m_neg_d;
    logic              is_div, a_signed, b_signed, sa, sb, neg_in, div_zero, div_ovf, div_ge;
    logic [XLEN:0]     mul_sum, rem_sh;

    always_comb begin : m_operands
        is_div   = Funct3E_i[2];
        a_signed = is_div ? !Funct3E_i[0] : (Funct3E_i[1:0] == 2'b01 || Funct3E_i[1:0] == 2'b10);
        b_signed = is_div ? !Funct3E_i[0] : (Funct3E_i[1:0] == 2'b01);
        sa       = a_signed && src_a[XLEN-1];
        sb       = b_signed && write_data[XLEN-1];
        mag_a    = sa ? -src_a : src_a;
        mag_b    = sb ? -write_data : write_data;
        neg_in   = (is_div && Funct3E_i[1]) ? sa : (sa ^ sb);
        div_zero = is_div && (write_data == '0);
        div_ovf  = is_div && !Funct3E_i[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (&write_data);
    end

    // The accumulator holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin : m_datapath
        mul_sum  = {1'b0, m_acc_q[2*XLEN-1:XLEN]} + (m_acc_q[0] ? {1'b0, m_opb_q} : '0);
        rem_sh   = m_acc_q[2*XLEN-1:XLEN-1];
        div_ge   = rem_sh >= {1'b0, m_opb_q};
        div_diff = rem_sh[XLEN-1:0] - m_opb_q;
        if (!m_op_q[2])  m_step = {mul_sum, m_acc_q[XLEN-1:1]};
        else if (div_ge) m_step = {div_diff, m_acc_q[XLEN-2:0], 1'b1};
        else             m_step = {rem_sh[XLEN-1:0], m_acc_q[XLEN-2:0], 1'b0};
        m_full  = m_neg_q ? -m_acc_q : m_acc_q;
        div_val = m_op_q[1] ? m_acc_q[2*XLEN-1:XLEN] : m_acc_q[XLEN-1:0];
        if (m_op_q[2])                 m_result = m_neg_q ? -div_val : div_val;
        else if (m_op_q[1:0] == 2'b00) m_result = m_full[XLEN-1:0];
        else                           m_result = m_full[2*XLEN-1:XLEN];
    end

    always_comb begin : m_next
        m_state_d = m_state_q;
        m_cnt_d   = m_cnt_q;
        m_acc_d   = m_acc_q;
        m_opb_d   = m_opb_q;
        m_op_d    = m_op_q;
        m_neg_d   = m_neg_q;
        busy      = 1'b0;
        m_done    = (m_state_q == M_DONE);
        case (m_state_q)
            M_IDLE: if (MulDivE_i && !FlushE_i) begin
                busy    = 1'b1;
                m_op_d  = Funct3E_i;
                m_opb_d = mag_b;
                m_cnt_d = CW'(XLEN);
                if (div_zero) begin
                    m_acc_d   = {src_a, {XLEN{1'b1}}};
                    m_neg_d   = 1'b0;
                    m_state_d = M_DONE;
                end else if (div_ovf) begin
                    m_acc_d   = {{XLEN{1'b0}}, src_a};
                    m_neg_d   = 1'b0;
                    m_state_d = M_DONE;
                end else begin
                    m_acc_d   = {{XLEN{1'b0}}, mag_a};
                    m_neg_d   = neg_in;
                    m_state_d = M_RUN;
                end
            end
            M_RUN: if (FlushE_i) begin
                m_state_d = M_IDLE;
            end else begin
                busy    = 1'b1;
                m_acc_d = m_step;
                m_cnt_d = m_cnt_q - CW'(1);
                if (m_cnt_q == CW'(1)) m_state_d = M_DONE;
            end
            default: m_state_d = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_state_q <= M_IDLE;
            m_cnt_q   <= '0;
            m_acc_q   <= '0;
            m_opb_q   <= '0;
            m_op_q    <= '0;
            m_neg_q   <= 1'b0;
        end else begin
            m_state_q <= m_state_d;
            m_cnt_q   <= m_cnt_d;
            m_acc_q   <= m_acc_d;
            m_opb_q   <= m_opb_d;
            m_op_q    <= m_op_d;
            m_neg_q   <= m_neg_d;
        end
    end
`else
    logic unused_muldiv;
    assign unused_muldiv = MulDivE_i;
    assign busy          = 1'b0;
    assign m_done        = 1'b0;
    assign m_result      = '0;
`endif

    assign BusyE_o = busy;

    // A stalled or flushed instruction leaves a bubble; only the control fields must be cleared.
    always_comb begin : em_next
        reg_write_d  = RegWriteE_i && !FlushE_i && !busy;
        mem_write_d  = MemWriteE_i && !FlushE_i && !busy;
        rd_d         = (FlushE_i || busy) ? '0 : RdE_i;
        alu_result_d = m_done ? m_result : alu_res;
        write_data_d = write_data;
        pc_plus4_d   = PCPlus4E_i;
        result_src_d = ResultSrcE_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            rd_q         <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
            result_src_q <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
            result_src_q <= result_src_d;
        end
    end

    assign RegWriteM_o  = reg_write_q;
    assign MemWriteM_o  = mem_write_q;
    assign RdM_o        = rd_q;
    assign ALUResultM_o = alu_result_q;
    assign WriteDataM_o = write_data_q;
    assign PCPlus4M_o   = pc_plus4_q;
    assign ResultSrcM_o = result_src_q;
endmodule

// File: tb/tb_exec_stage.sv
// Directed-vector bench for exec_stage; the M-unit vectors run only when RV32M_EN is defined.
module tb_exec_stage;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, MulDivE, FlushE;
    logic [1:0]        ResultSrcE, ForwardAE, ForwardBE;
    logic [2:0]        Funct3E;
    logic [3:0]        ALUControlE;
    logic [XLEN-1:0]   RD1E, RD2E, PCE, PCPlus4E, ImmExtE, ResultW;
    logic [REG_AW-1:0] RdE;
    logic              PCSrcE_o, BusyE_o, RegWriteM_o, MemWriteM_o;
    logic [XLEN-1:0]   PCTargetE_o, ALUResultM_o, WriteDataM_o, PCPlus4M_o;
    logic [REG_AW-1:0] RdM_o;
    logic [1:0]        ResultSrcM_o;

    always #5 clk = ~clk;

    exec_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE_i(RegWriteE), .ResultSrcE_i(ResultSrcE), .MemWriteE_i(MemWriteE),
        .JumpE_i(JumpE), .JalrE_i(JalrE), .BranchE_i(BranchE), .Funct3E_i(Funct3E),
        .ALUControlE_i(ALUControlE), .ALUSrcE_i(ALUSrcE), .MulDivE_i(MulDivE),
        .RD1E_i(RD1E), .RD2E_i(RD2E), .PCE_i(PCE), .PCPlus4E_i(PCPlus4E), .ImmExtE_i(ImmExtE),
        .RdE_i(RdE), .ForwardAE_i(ForwardAE), .ForwardBE_i(ForwardBE), .ResultW_i(ResultW),
        .FlushE_i(FlushE), .PCSrcE_o(PCSrcE_o), .PCTargetE_o(PCTargetE_o), .BusyE_o(BusyE_o),
        .ALUResultM_o(ALUResultM_o), .WriteDataM_o(WriteDataM_o), .PCPlus4M_o(PCPlus4M_o),
        .RdM_o(RdM_o), .RegWriteM_o(RegWriteM_o), .MemWriteM_o(MemWriteM_o),
        .ResultSrcM_o(ResultSrcM_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RegWriteE = 0; MemWriteE = 0; JumpE = 0; JalrE = 0; BranchE = 0; ALUSrcE = 0;
        MulDivE = 0; FlushE = 0; ResultSrcE = 0; ForwardAE = 0; ForwardBE = 0; Funct3E = 0;
        ALUControlE = 0; RD1E = 0; RD2E = 0; PCE = 0; PCPlus4E = 0; ImmExtE = 0; ResultW = 0;
        RdE = 0;
    endtask

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    localparam int N_ALU = 11;
    alu_vec_t alu_vecs [N_ALU] = '{
        '{4'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE},
        '{4'd2,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0},
        '{4'd3,  32'h0000_F000, 32'h0000_000F, 32'h0000_F00F},
        '{4'd4,  32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0},
        '{4'd5,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
        '{4'd6,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
        '{4'd7,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002},
        '{4'd8,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000},
        '{4'd9,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000},
        '{4'd10, 32'h1234_5678, 32'h0000_1234, 32'h0000_1234},
        '{4'd15, 32'h1234_5678, 32'h0000_1234, 32'h0000_0000}
    };

`ifdef RV32M_EN
    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [7:0]  cycles;
    } mop_vec_t;

    localparam int N_MOP = 8;
    mop_vec_t mop_vecs [N_MOP] = '{
        '{3'b000, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 8'd33},
        '{3'b011, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0002, 8'd33},
        '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 8'd33},
        '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 8'd33},
        '{3'b101, 32'd100,       32'd7,         32'd14,        8'd33},
        '{3'b111, 32'd100,       32'd7,         32'd2,         8'd33},
        '{3'b100, 32'd7,         32'd0,         32'hFFFF_FFFF, 8'd1},
        '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 8'd1}
    };

    // Presents an M-op, counts busy cycles (bounded), then steps over the DONE edge.
    task automatic run_mop(input mop_vec_t v, output int cyc);
        clear_inputs();
        MulDivE = 1; Funct3E = v.f3; RD1E = v.a; RD2E = v.b; RegWriteE = 1; RdE = 5'd5;
        #1;
        cyc = 0;
        while (BusyE_o && cyc < 200) begin
            cyc++;
            tick();
            if (cyc == 1) check("mop stall bubble", {31'b0, RegWriteM_o}, 32'd0);
        end
        tick();
        MulDivE = 0; RegWriteE = 0;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_wr;
        clear_inputs();
        rst = 1;
        tick();
        tick();
        check("reset ALUResultM", ALUResultM_o, 32'd0);
        check("reset RegWriteM", {31'b0, RegWriteM_o}, 32'd0);
        check("reset RdM", {27'b0, RdM_o}, 32'd0);
        check("reset BusyE", {31'b0, BusyE_o}, 32'd0);
        check("reset PCSrcE", {31'b0, PCSrcE_o}, 32'd0);
        rst = 0;

        RD1E = 2; ImmExtE = 3; ALUSrcE = 1; RegWriteE = 1; RdE = 5'd3; ResultSrcE = 2'd2;
        tick();
        check("add 2+3", ALUResultM_o, 32'd5);
        check("add RdM", {27'b0, RdM_o}, 32'd3);
        check("add RegWriteM", {31'b0, RegWriteM_o}, 32'd1);
        check("add ResultSrcM", {30'b0, ResultSrcM_o}, 32'd2);

        ForwardAE = 2'b10; ImmExtE = 7;
        tick();
        check("add fwdA=MEM", ALUResultM_o, 32'd12);

        ForwardAE = 2'b01; ResultW = 100; ForwardBE = 2'b10; ALUSrcE = 0; ALUControlE = 4'd1;
        PCPlus4E = 32'h44;
        tick();
        check("sub fwdA=WB fwdB=MEM", ALUResultM_o, 32'd88);
        check("WriteDataM fwdB", WriteDataM_o, 32'd12);
        check("PCPlus4M", PCPlus4M_o, 32'h44);

        clear_inputs();
        ALUSrcE = 1;
        for (int i = 0; i < N_ALU; i++) begin
            ALUControlE = alu_vecs[i].op; RD1E = alu_vecs[i].a; ImmExtE = alu_vecs[i].b;
            tick();
            check($sformatf("alu op%0d", alu_vecs[i].op), ALUResultM_o, alu_vecs[i].exp);
        end

        clear_inputs();
        BranchE = 1; Funct3E = 3'b100; RD1E = 32'hFFFF_FFFF; RD2E = 1; ALUSrcE = 1;
        PCE = 32'h100; ImmExtE = 32'h20;
        #1;
        check("blt -1<1", {31'b0, PCSrcE_o}, 32'd1);
        check("branch target", PCTargetE_o, 32'h120);
        Funct3E = 3'b110; #1;
        check("bltu -1<1", {31'b0, PCSrcE_o}, 32'd0);
        Funct3E = 3'b111; #1;
        check("bgeu -1>=1", {31'b0, PCSrcE_o}, 32'd1);
        RD2E = 32'hFFFF_FFFF; Funct3E = 3'b000; #1;
        check("beq equal", {31'b0, PCSrcE_o}, 32'd1);
        Funct3E = 3'b010; #1;
        check("funct3 010 never", {31'b0, PCSrcE_o}, 32'd0);
        Funct3E = 3'b000; FlushE = 1; #1;
        check("beq flushed", {31'b0, PCSrcE_o}, 32'd0);

        clear_inputs();
        JumpE = 1; JalrE = 1; RD1E = 32'h1001; ImmExtE = 4; PCE = 32'h8000;
        #1;
        check("jalr target", PCTargetE_o, 32'h1004);
        check("jalr PCSrcE", {31'b0, PCSrcE_o}, 32'd1);
        JalrE = 0; #1;
        check("jal target", PCTargetE_o, 32'h8004);

        clear_inputs();
        RegWriteE = 1; MemWriteE = 1; RdE = 5'd7; FlushE = 1;
        tick();
        check("flush RegWriteM", {31'b0, RegWriteM_o}, 32'd0);
        check("flush MemWriteM", {31'b0, MemWriteM_o}, 32'd0);
        check("flush RdM", {27'b0, RdM_o}, 32'd0);
        FlushE = 0;
        tick();
        check("unflushed MemWriteM", {31'b0, MemWriteM_o}, 32'd1);
        check("unflushed RdM", {27'b0, RdM_o}, 32'd7);

`ifdef RV32M_EN
        for (int i = 0; i < N_MOP; i++) begin
            int cyc;
            run_mop(mop_vecs[i], cyc);
            check($sformatf("mop%0d busy cycles", i), cyc, {24'b0, mop_vecs[i].cycles});
            check($sformatf("mop%0d result", i), ALUResultM_o, mop_vecs[i].exp);
            check($sformatf("mop%0d RegWriteM", i), {31'b0, RegWriteM_o}, 32'd1);
        end

        clear_inputs();
        MulDivE = 1; Funct3E = 3'b101; RD1E = 32'd100; RD2E = 32'd7; RegWriteE = 1; RdE = 5'd9;
        for (int i = 0; i < 11; i++) tick();
        FlushE = 1; #1;
        check("divu flush busy drop", {31'b0, BusyE_o}, 32'd0);
        tick();
        check("divu flush RegWriteM", {31'b0, RegWriteM_o}, 32'd0);
        clear_inputs();
        #1;
        check("divu flush idle", {31'b0, BusyE_o}, 32'd0);
        bad_wr = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (RegWriteM_o !== 1'b0 || BusyE_o !== 1'b0) bad_wr++;
        end
        check("divu flush no result", bad_wr, 32'd0);

        MulDivE = 1; Funct3E = 3'b000; RD1E = 32'd6; RD2E = 32'd7; RegWriteE = 1; RdE = 5'd4;
        for (int i = 0; i < 6; i++) tick();
        rst = 1; clear_inputs();
        tick();
        rst = 0; #1;
        check("rst mid-run idle", {31'b0, BusyE_o}, 32'd0);
        check("rst mid-run RegWriteM", {31'b0, RegWriteM_o}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
